solver_run_monitor: RTL and testbench

- Synthesizable run controller and result collector for NUM_CH parallel puzzle solvers inside Top.
- Issues one start pulse to all solvers and timestamps each channel's first Done.
- Latches each channel's Answer, enforces a cycle-count watchdog, and drives the board-level Done/Error pair.
- Replaces the per-day simulation-only result print: answers and cycle counts are readable in hardware through a select port.

---
 rtl/solver_pkg.sv | 28 ++
 rtl/solver_run_monitor_if.sv | 32 +++
 rtl/solver_channel_capture.sv | 43 ++++
 rtl/solver_run_monitor.sv | 185 ++++++++++++++++++
 tb/tb_solver_run_monitor.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/solver_pkg.sv
// ----------------------------------------------------------------------------
// solver_pkg
// Shared definitions for the solver run monitor: run-state encoding, error
// code values, the default system clock rate used to derive the watchdog
// limit, and a helper that sizes channel-select fields.
// ----------------------------------------------------------------------------
package solver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CH      = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // One second of watchdog at the board clock.
    localparam longint unsigned CLK_HZ = 64'd125000000;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/solver_run_monitor_if.sv
// ----------------------------------------------------------------------------
// solver_run_monitor_if
// Bundle between the run monitor and its NUM_CH solver channels.
//   ChStart  : one-cycle launch pulse, monitor -> solvers
//   ChDone   : per-channel done level, solvers -> monitor
//   ChError  : per-channel error level, solvers -> monitor
//   ChAnswer : packed answers, channel i at [i*ANS_W +: ANS_W]
// master = monitor side, slave = solver side.
// ----------------------------------------------------------------------------
interface solver_run_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int ANS_W  = 64
);
    logic                      ChStart;
    logic [NUM_CH-1:0]         ChDone;
    logic [NUM_CH-1:0]         ChError;
    logic [NUM_CH*ANS_W-1:0]   ChAnswer;

    modport master (
        output ChStart,
        input  ChDone,
        input  ChError,
        input  ChAnswer
    );

    modport slave (
        input  ChStart,
        output ChDone,
        output ChError,
        output ChAnswer
    );
endinterface

// File: rtl/solver_channel_capture.sv
// ----------------------------------------------------------------------------
// solver_channel_capture
// One channel's result holder: a complete flag plus the answer and the cycle
// count at which the channel first reported done. Only the first capture of
// a run is kept; clr wipes the channel when a new run is launched.
//   Clk, Rst  : clock, synchronous active-high reset
//   clr       : start of a new run, clears flag and captures
//   cap_en    : capture ans_in/cyc_in and set complete (parent gates with
//               ~complete, so this fires once per run)
//   ans_in    : channel answer
//   cyc_in    : current run cycle count
//   complete  : channel has completed this run
//   answer    : captured answer
//   cycles    : captured completion cycle
// ----------------------------------------------------------------------------
module solver_channel_capture #(
    parameter int ANS_W = 64,
    parameter int CYC_W = 40
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr,
    input  logic             cap_en,
    input  logic [ANS_W-1:0] ans_in,
    input  logic [CYC_W-1:0] cyc_in,
    output logic             complete,
    output logic [ANS_W-1:0] answer,
    output logic [CYC_W-1:0] cycles
);

    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            complete <= 1'b0;
            answer   <= '0;
            cycles   <= '0;
        end else if (cap_en) begin
            complete <= 1'b1;
            answer   <= ans_in;
            cycles   <= cyc_in;
        end
    end

endmodule

// File: rtl/solver_run_monitor.sv
// ----------------------------------------------------------------------------
// solver_run_monitor
// Launches NUM_CH puzzle solvers together, timestamps each channel's first
// done, latches its answer, runs a cycle watchdog and reports the board-level
// Done/Error outcome. Results stay readable through the RdSel port.
//   Clk, Rst   : clock, synchronous active-high reset
//   Start      : launch a run (ignored while a run is in progress)
//   ch         : solver bundle (ChStart out; ChDone/ChError/ChAnswer in)
//   RdSel      : readback channel select
//   RdAnswer   : captured answer of RdSel (0 if out of range)
//   RdCycles   : captured completion cycle of RdSel (0 if out of range)
//   RdValid    : RdSel completed this run
//   Busy       : run in progress
//   Done       : sticky, every channel completed without error
//   Error      : sticky, channel error or watchdog expiry
//   ErrCode    : ERR_NONE / ERR_CH / ERR_TIMEOUT
//   ErrCh      : lowest failing channel, 0 on timeout
// ----------------------------------------------------------------------------
module solver_run_monitor
    import solver_pkg::*;
#(
    parameter int              NUM_CH  = 4,
    parameter int              ANS_W   = 64,
    parameter int              CYC_W   = 40,
    parameter longint unsigned TIMEOUT = CLK_HZ,
    localparam int             SEL_W   = sel_width(NUM_CH)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    solver_run_monitor_if.master ch,
    input  logic [SEL_W-1:0]     RdSel,
    output logic [ANS_W-1:0]     RdAnswer,
    output logic [CYC_W-1:0]     RdCycles,
    output logic                 RdValid,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error,
    output logic [1:0]           ErrCode,
    output logic [SEL_W-1:0]     ErrCh
);

    localparam logic [CYC_W-1:0] CNT_MAX = '1;
    // Counter value of the last cycle the watchdog allows.
    localparam logic [CYC_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CYC_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cnt_q;
    logic               chstart_q;
    logic               done_q;
    logic               error_q;
    logic [1:0]         errcode_q;
    logic [SEL_W-1:0]   errch_q;

    logic               start_run;
    logic               sample;
    logic [NUM_CH-1:0]  done_hit;
    logic [NUM_CH-1:0]  err_hit;
    logic [NUM_CH-1:0]  cap_en;
    logic [NUM_CH-1:0]  complete;
    logic               all_done;
    logic               any_err;
    logic               timeout_hit;
    logic [SEL_W-1:0]   low_err;

    logic [ANS_W-1:0]   ans_arr [NUM_CH];
    logic [CYC_W-1:0]   cyc_arr [NUM_CH];

    // Channel levels are only trusted from the second RUN cycle on, so levels
    // still standing from the previous run cannot complete the new one.
    always_comb begin
        start_run   = Start && (state_q != RUN);
        sample      = (state_q == RUN) && (cnt_q != '0);
        done_hit    = sample ? ch.ChDone  : '0;
        err_hit     = sample ? ch.ChError : '0;
        cap_en      = done_hit & ~complete;
        all_done    = &(complete | done_hit);
        any_err     = |err_hit;
        // Incompleteness is judged before this cycle's captures, so a channel
        // finishing exactly on the last allowed cycle still times out.
        timeout_hit = (TIMEOUT != 0) && (state_q == RUN) &&
                      (cnt_q == TO_LAST) && !(&complete);
        low_err     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (err_hit[i]) begin
                low_err = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FINISH, FAULT: begin
                if (Start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (any_err || timeout_hit) begin
                    state_d = FAULT;
                end else if (all_done) begin
                    state_d = FINISH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            chstart_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            errcode_q <= ERR_NONE;
            errch_q   <= '0;
        end else begin
            state_q   <= state_d;
            chstart_q <= start_run;
            if (start_run) begin
                cnt_q     <= '0;
                done_q    <= 1'b0;
                error_q   <= 1'b0;
                errcode_q <= ERR_NONE;
                errch_q   <= '0;
            end else if (state_q == RUN) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (any_err) begin
                    error_q   <= 1'b1;
                    errcode_q <= ERR_CH;
                    errch_q   <= low_err;
                end else if (timeout_hit) begin
                    error_q   <= 1'b1;
                    errcode_q <= ERR_TIMEOUT;
                    errch_q   <= '0;
                end else if (all_done) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        solver_channel_capture #(
            .ANS_W (ANS_W),
            .CYC_W (CYC_W)
        ) u_cap (
            .Clk      (Clk),
            .Rst      (Rst),
            .clr      (start_run),
            .cap_en   (cap_en[g]),
            .ans_in   (ch.ChAnswer[g*ANS_W +: ANS_W]),
            .cyc_in   (cnt_q),
            .complete (complete[g]),
            .answer   (ans_arr[g]),
            .cycles   (cyc_arr[g])
        );
    end

    // Selects beyond the last channel match nothing and read back as zero.
    always_comb begin
        RdAnswer = '0;
        RdCycles = '0;
        RdValid  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (RdSel == SEL_W'(i)) begin
                RdAnswer = ans_arr[i];
                RdCycles = cyc_arr[i];
                RdValid  = complete[i];
            end
        end
    end

    assign ch.ChStart = chstart_q;
    assign Busy       = (state_q == RUN);
    assign Done       = done_q;
    assign Error      = error_q;
    assign ErrCode    = errcode_q;
    assign ErrCh      = errch_q;

endmodule

// File: tb/tb_solver_run_monitor.sv
// ----------------------------------------------------------------------------
// tb_solver_run_monitor
// Self-checking bench for solver_run_monitor (NUM_CH=4, TIMEOUT=50).
// Each run is described by per-channel done/error run cycles; expected
// outcomes come from an event-ordering model of the run rules.
// ----------------------------------------------------------------------------
module tb_solver_run_monitor;

    localparam int NCH    = 4;
    localparam int AW     = 64;
    localparam int CW     = 40;
    localparam int TO     = 50;
    localparam int T_LAST = TO - 1;
    localparam int NEVER  = 100000;

    typedef int          iarr_t [NCH];
    typedef logic [63:0] aarr_t [NCH];

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Start;
    logic [1:0]    RdSel;
    logic [AW-1:0] RdAnswer;
    logic [CW-1:0] RdCycles;
    logic          RdValid;
    logic          Busy;
    logic          Done;
    logic          Error;
    logic [1:0]    ErrCode;
    logic [1:0]    ErrCh;

    int errors = 0;
    int checks = 0;

    solver_run_monitor_if #(.NUM_CH(NCH), .ANS_W(AW)) ch_if ();

    solver_run_monitor #(
        .NUM_CH  (NCH),
        .ANS_W   (AW),
        .CYC_W   (CW),
        .TIMEOUT (TO)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .ch       (ch_if),
        .RdSel    (RdSel),
        .RdAnswer (RdAnswer),
        .RdCycles (RdCycles),
        .RdValid  (RdValid),
        .Busy     (Busy),
        .Done     (Done),
        .Error    (Error),
        .ErrCode  (ErrCode),
        .ErrCh    (ErrCh)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got stuck required completion");
        $fatal(1, "bench stuck");
    end

    function automatic int capc(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    // Outcome by event ordering: first error, all-channels-complete, or the
    // watchdog on cycle T_LAST (which beats a completion on that same cycle).
    // Errors win any tie.
    function automatic void model(input iarr_t d, input iarr_t e,
                                  output int dec, output int code, output int ech);
        int emin = NEVER;
        int dall = 0;
        int fin;
        int tmo;
        for (int i = 0; i < NCH; i++) begin
            if (e[i] < emin) emin = e[i];
            if (capc(d[i]) > dall) dall = capc(d[i]);
        end
        fin  = (dall < T_LAST) ? dall : NEVER;
        tmo  = (dall >= T_LAST) ? T_LAST : NEVER;
        dec  = (fin < tmo) ? fin : tmo;
        code = (tmo < fin) ? 2 : 0;
        ech  = 0;
        if (emin <= dec) begin
            dec  = emin;
            code = 1;
            for (int i = NCH - 1; i >= 0; i--) if (e[i] == emin) ech = i;
        end
    endfunction

    // Launches a run and drives channel levels cycle by cycle until Busy
    // drops; returns the run cycle of the decisive edge (-1 if none).
    task automatic drive_run(input iarr_t d, input iarr_t e, input aarr_t a,
                             input string tag, output int dec_obs);
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        dec_obs = -1;
        for (int c = 0; c < 200 && dec_obs < 0; c++) begin
            for (int i = 0; i < NCH; i++) begin
                ch_if.ChDone[i]  = (c >= d[i]);
                ch_if.ChError[i] = (c >= e[i]);
                ch_if.ChAnswer[i*AW +: AW] = (c == capc(d[i])) ? a[i] : {$urandom, $urandom};
            end
            @(negedge Clk);
            checks++;
            if (ch_if.ChStart !== 1'(c == 0)) begin
                errors++;
                $display("FAIL %s_chstart c=%0d: got %b required %b", tag, c, ch_if.ChStart, (c == 0));
            end
            checks++;
            if ({Busy, Done, Error} !== 3'b100) begin
                errors++;
                $display("FAIL %s_inrun c=%0d: busy/done/error got %b required 100", tag, c, {Busy, Done, Error});
            end
            @(posedge Clk); #1;
            if (Busy === 1'b0) dec_obs = c;
        end
        if (dec_obs < 0) begin
            errors++;
            $display("FAIL %s_end: run never ended, got busy required idle within 200 cycles", tag);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Start = 1'b0;
        RdSel = '0;
        ch_if.ChDone = '0;
        ch_if.ChError = '0;
        ch_if.ChAnswer = '0;
        do_reset();
        checks++;
        if ({ch_if.ChStart, Busy, Done, Error, ErrCode, ErrCh} !== 8'b0) begin
            errors++;
            $display("FAIL reset_status: got %b required 00000000",
                     {ch_if.ChStart, Busy, Done, Error, ErrCode, ErrCh});
        end
        for (int s = 0; s < NCH; s++) begin
            RdSel = 2'(s); #1;
            checks++;
            if (RdValid !== 1'b0 || RdCycles !== '0 || RdAnswer !== '0) begin
                errors++;
                $display("FAIL reset_rd sel=%0d: got v=%b c=%0d a=%0d required 0", s, RdValid, RdCycles, RdAnswer);
            end
        end
    endtask

    task automatic test_basic();
        iarr_t d = '{5, 9, 3, 20};
        iarr_t e = '{NEVER, NEVER, NEVER, NEVER};
        aarr_t a = '{64'd11, 64'd22, 64'd33, 64'd44};
        int dec;
        repeat (8) @(posedge Clk);
        drive_run(d, e, a, "basic", dec);
        checks++;
        if (dec !== 20 || Done !== 1'b1 || Error !== 1'b0 || ErrCode !== 2'b00) begin
            errors++;
            $display("FAIL basic_outcome: got dec=%0d done=%b err=%b code=%0d required 20 1 0 0", dec, Done, Error, ErrCode);
        end
        for (int s = 0; s < NCH; s++) begin
            RdSel = 2'(s); #1;
            checks++;
            if (RdValid !== 1'b1 || RdCycles !== CW'(d[s]) || RdAnswer !== a[s]) begin
                errors++;
                $display("FAIL basic_rd sel=%0d: got v=%b c=%0d a=%0d required 1 %0d %0d",
                         s, RdValid, RdCycles, RdAnswer, d[s], a[s]);
            end
        end
    endtask

    task automatic test_stale_done();
        iarr_t d = '{4, 6, 0, 8};
        iarr_t e = '{NEVER, NEVER, NEVER, NEVER};
        aarr_t a = '{64'h1234, 64'h5678, 64'h9abc, 64'hdef0};
        int dec;
        do_reset();
        ch_if.ChDone = 4'b0100;
        ch_if.ChAnswer[2*AW +: AW] = 64'hbad;
        repeat (4) @(posedge Clk);
        #1;
        RdSel = 2'd2; #1;
        checks++;
        if (RdValid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_idle: got valid=%b busy=%b required 0 0", RdValid, Busy);
        end
        drive_run(d, e, a, "stale", dec);
        RdSel = 2'd2; #1;
        checks++;
        if (dec !== 8 || RdValid !== 1'b1 || RdCycles !== 40'd1 || RdAnswer !== a[2]) begin
            errors++;
            $display("FAIL stale_capture: got dec=%0d v=%b c=%0d a=%0h required 8 1 1 %0h",
                     dec, RdValid, RdCycles, RdAnswer, a[2]);
        end
    endtask

    task automatic test_error();
        iarr_t d = '{7, NEVER, NEVER, NEVER};
        iarr_t e = '{NEVER, 7, NEVER, 7};
        aarr_t a = '{64'd77, 64'd1, 64'd2, 64'd3};
        int dec;
        drive_run(d, e, a, "cherr", dec);
        checks++;
        if (dec !== 7 || Error !== 1'b1 || Done !== 1'b0 || ErrCode !== 2'b01 || ErrCh !== 2'd1) begin
            errors++;
            $display("FAIL cherr_outcome: got dec=%0d err=%b done=%b code=%0d ch=%0d required 7 1 0 1 1",
                     dec, Error, Done, ErrCode, ErrCh);
        end
        RdSel = 2'd0; #1;
        checks++;
        if (RdValid !== 1'b1 || RdCycles !== 40'd7 || RdAnswer !== 64'd77) begin
            errors++;
            $display("FAIL cherr_ch0: got v=%b c=%0d a=%0d required 1 7 77", RdValid, RdCycles, RdAnswer);
        end
        RdSel = 2'd3; #1;
        checks++;
        if (RdValid !== 1'b0) begin
            errors++;
            $display("FAIL cherr_ch3: got valid=%b required 0", RdValid);
        end
    endtask

    task automatic test_timeout_restart();
        iarr_t d  = '{3, 4, NEVER, 10};
        iarr_t d2 = '{1, 2, 3, 4};
        iarr_t e  = '{NEVER, NEVER, NEVER, NEVER};
        aarr_t a  = '{64'd5, 64'd6, 64'd7, 64'd8};
        int dec;
        drive_run(d, e, a, "tmo", dec);
        checks++;
        if (dec !== 49 || Error !== 1'b1 || Done !== 1'b0 || ErrCode !== 2'b10 || ErrCh !== 2'd0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_outcome: got dec=%0d err=%b done=%b code=%0d ch=%0d busy=%b required 49 1 0 2 0 0",
                     dec, Error, Done, ErrCode, ErrCh, Busy);
        end
        RdSel = 2'd2; #1;
        checks++;
        if (RdValid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_ch2: got valid=%b required 0", RdValid);
        end
        drive_run(d2, e, a, "relaunch", dec);
        RdSel = 2'd0; #1;
        checks++;
        if (dec !== 4 || Error !== 1'b0 || Done !== 1'b1 || ErrCode !== 2'b00 || RdCycles !== 40'd1) begin
            errors++;
            $display("FAIL relaunch: got dec=%0d err=%b done=%b code=%0d c0=%0d required 4 0 1 0 1",
                     dec, Error, Done, ErrCode, RdCycles);
        end
    endtask

    task automatic test_timeout_tie();
        iarr_t d = '{2, 3, 49, 10};
        iarr_t e = '{NEVER, NEVER, NEVER, NEVER};
        aarr_t a = '{64'd9, 64'd8, 64'd4242, 64'd6};
        int dec;
        drive_run(d, e, a, "tie", dec);
        checks++;
        if (dec !== 49 || Error !== 1'b1 || Done !== 1'b0 || ErrCode !== 2'b10) begin
            errors++;
            $display("FAIL tie_outcome: got dec=%0d err=%b done=%b code=%0d required 49 1 0 2", dec, Error, Done, ErrCode);
        end
        RdSel = 2'd2; #1;
        checks++;
        if (RdValid !== 1'b1 || RdCycles !== 40'd49 || RdAnswer !== 64'd4242) begin
            errors++;
            $display("FAIL tie_ch2: got v=%b c=%0d a=%0d required 1 49 4242", RdValid, RdCycles, RdAnswer);
        end
    endtask

    task automatic test_rst_midrun();
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ch_if.ChDone  = {2'b00, 1'(c >= 2), 1'(c >= 1)};
            ch_if.ChError = '0;
            @(posedge Clk); #1;
        end
        RdSel = 2'd1; #1;
        checks++;
        if (RdValid !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got valid=%b busy=%b required 1 1", RdValid, Busy);
        end
        Rst   = 1'b1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Rst   = 1'b0;
        Start = 1'b0;
        checks++;
        if ({ch_if.ChStart, Busy, Done, Error, ErrCode, ErrCh} !== 8'b0) begin
            errors++;
            $display("FAIL rst_status: got %b required 00000000",
                     {ch_if.ChStart, Busy, Done, Error, ErrCode, ErrCh});
        end
        for (int s = 0; s < NCH; s++) begin
            RdSel = 2'(s); #1;
            checks++;
            if (RdValid !== 1'b0 || RdCycles !== '0 || RdAnswer !== '0) begin
                errors++;
                $display("FAIL rst_rd sel=%0d: got v=%b c=%0d a=%0d required 0", s, RdValid, RdCycles, RdAnswer);
            end
        end
        @(posedge Clk); #1;
        checks++;
        if (Busy !== 1'b0 || ch_if.ChStart !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_ignored: got busy=%b chstart=%b required 0 0", Busy, ch_if.ChStart);
        end
    endtask

    task automatic test_random();
        iarr_t d;
        iarr_t e;
        aarr_t a;
        int dec, dec_m, code_m, ech_m;
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NCH; i++) begin
                d[i] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 60));
                e[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 60)) : NEVER;
                a[i] = {$urandom, $urandom};
            end
            model(d, e, dec_m, code_m, ech_m);
            drive_run(d, e, a, "rand", dec);
            checks++;
            if (dec !== dec_m || ErrCode !== 2'(code_m) || Error !== 1'(code_m != 0) ||
                Done !== 1'(code_m == 0) || (code_m == 1 && ErrCh !== 2'(ech_m))) begin
                errors++;
                $display("FAIL rand_outcome n=%0d: got dec=%0d code=%0d ch=%0d done=%b err=%b required dec=%0d code=%0d ch=%0d",
                         n, dec, ErrCode, ErrCh, Done, Error, dec_m, code_m, ech_m);
            end
            for (int s = 0; s < NCH; s++) begin
                RdSel = 2'(s); #1;
                checks++;
                if (capc(d[s]) <= dec_m) begin
                    if (RdValid !== 1'b1 || RdCycles !== CW'(capc(d[s])) || RdAnswer !== a[s]) begin
                        errors++;
                        $display("FAIL rand_rd n=%0d sel=%0d: got v=%b c=%0d a=%0h required 1 %0d %0h",
                                 n, s, RdValid, RdCycles, RdAnswer, capc(d[s]), a[s]);
                    end
                end else if (RdValid !== 1'b0 || RdCycles !== '0 || RdAnswer !== '0) begin
                    errors++;
                    $display("FAIL rand_rd n=%0d sel=%0d: got v=%b c=%0d a=%0h required 0 0 0",
                             n, s, RdValid, RdCycles, RdAnswer);
                end
            end
            repeat ($urandom_range(0, 3)) @(posedge Clk);
        end
    endtask

    initial begin
        Rst   = 1'b1;
        Start = 1'b0;
        RdSel = '0;
        test_reset();
        test_basic();
        test_stale_done();
        test_error();
        test_timeout_restart();
        test_timeout_tie();
        test_rst_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
